// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/decode boundary.
// Provides the IF/ID state encoding, the entry record carried between the two
// stages, and the bubble encoding presented to decode.
package cpu_pkg;

  localparam int XLEN = 32;

  // Instruction word decode treats as a no-op bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // output register holds a bubble
    FULL  = 2'd1,  // output register valid, skid empty
    SKID  = 2'd2   // output register and skid both valid
  } ifid_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus_4;
    logic            interrupt;
  } ifid_entry_t;

  // Turn an entry into a bubble. PC+4 is kept so decode still sees the last
  // real PC+4 while the pipeline is idle.
  function automatic ifid_entry_t make_bubble(input ifid_entry_t e,
                                              input logic [XLEN-1:0] nop);
    ifid_entry_t b;
    b.instr     = nop;
    b.pc_plus_4 = e.pc_plus_4;
    b.interrupt = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_entry_reg.sv
// Purpose: one IF/ID entry register (instr, PC+4, interrupt tag).
// Latency: 1 cycle from load to q; clear has priority over load.
// Backpressure: none; the owner decides when to load or clear.
// Ports: clk/rst (async active-high), load (capture d), clear (turn into a
//        bubble), d (incoming entry), q (held entry).
module ifid_entry_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  ifid_entry_t d,
  output ifid_entry_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '{instr: NOP, pc_plus_4: '0, interrupt: 1'b0};
    end else if (clear) begin
      q <= make_bubble(q, NOP);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// Purpose: IF/ID pipeline register with a one-entry skid for in-flight fetches.
// Latency: 1 cycle from accepted fetch to decode outputs when not stalled.
// Backpressure: fetch_stall is high while the skid is occupied; flush drops everything.
// Ports: clk, rst (async active-high); stall/flush from hazard unit;
//        instr_valid/instr_in/pc_plus_4_in/interrupt_in from fetch;
//        instr_out/pc_plus_4_out/interrupt_out/valid_out to decode; fetch_stall to fetch.
module if_id_buffer
  import cpu_pkg::XLEN, cpu_pkg::ifid_state_t, cpu_pkg::ifid_entry_t,
         cpu_pkg::EMPTY, cpu_pkg::FULL, cpu_pkg::SKID;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_plus_4_in,
  input  logic              interrupt_in,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc_plus_4_out,
  output logic              interrupt_out,
  output logic              valid_out,
  output logic              fetch_stall
);

  // The entry record is fixed to the package word width.
  if (DATA_W != XLEN) begin : g_width_check
    $error("if_id_buffer: DATA_W must equal cpu_pkg::XLEN");
  end

  ifid_state_t state, state_nxt;
  ifid_entry_t in_entry, out_d, out_q, skid_q;
  logic        accept;
  logic        out_load, out_clear, out_from_skid;
  logic        skid_load, skid_clear;

  // flush suppresses acceptance of a same-cycle fetch.
  assign accept   = instr_valid & ~flush;
  assign in_entry = '{instr: instr_in, pc_plus_4: pc_plus_4_in, interrupt: interrupt_in};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state_nxt = FULL;
        FULL: begin
          if (stall) state_nxt = accept ? SKID : FULL;
          else       state_nxt = accept ? FULL : EMPTY;
        end
        SKID:    if (!stall) state_nxt = FULL;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Datapath control
  always_comb begin
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        // A bubble may be overwritten even while decode is stalled.
        EMPTY: out_load = accept;
        FULL: begin
          if (stall) begin
            skid_load = accept;
          end else begin
            out_load  = accept;
            out_clear = ~accept;
          end
        end
        // Any fetch presented here is ignored; only the skid drains.
        SKID: begin
          if (!stall) begin
            out_load      = 1'b1;
            out_from_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: out_clear = 1'b1;
      endcase
    end
  end

  assign out_d = out_from_skid ? skid_q : in_entry;

  ifid_entry_reg #(.NOP(NOP_INSTR)) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .clear (out_clear),
    .d     (out_d),
    .q     (out_q)
  );

  ifid_entry_reg #(.NOP(NOP_INSTR)) u_skid_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Outputs
  assign instr_out     = out_q.instr;
  assign pc_plus_4_out = out_q.pc_plus_4;
  assign interrupt_out = out_q.interrupt;
  assign valid_out     = (state != EMPTY);
  assign fetch_stall   = (state == SKID);

  // Fetch must hold off while the skid is occupied (a flush cycle is exempt).
  a_no_fetch_in_skid: assert property (
    @(posedge clk) disable iff (rst) (state == SKID && !flush) |-> !instr_valid);

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, instr_valid, interrupt_in;
  logic [31:0] instr_in, pc_plus_4_in;
  logic [31:0] instr_out, pc_plus_4_out;
  logic        interrupt_out, valid_out, fetch_stall;

  int total = 0;
  int bad   = 0;

  if_id_buffer #(.DATA_W(32), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
    .pc_plus_4_in  (pc_plus_4_in),
    .interrupt_in  (interrupt_in),
    .instr_out     (instr_out),
    .pc_plus_4_out (pc_plus_4_out),
    .interrupt_out (interrupt_out),
    .valid_out     (valid_out),
    .fetch_stall   (fetch_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic eint, input logic efs);
    chk({tag, " valid_out"},     {31'd0, valid_out},     {31'd0, ev});
    chk({tag, " instr_out"},     instr_out,              ei);
    chk({tag, " pc_plus_4_out"}, pc_plus_4_out,          ep);
    chk({tag, " interrupt_out"}, {31'd0, interrupt_out}, {31'd0, eint});
    chk({tag, " fetch_stall"},   {31'd0, fetch_stall},   {31'd0, efs});
  endtask

  task automatic drive(input logic s, input logic f, input logic iv,
                       input logic [31:0] ins, input logic [31:0] pc, input logic intr);
    stall = s; flush = f; instr_valid = iv;
    instr_in = ins; pc_plus_4_in = pc; interrupt_in = intr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset entry: assert, hold across an edge, release after an edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        s, f, iv;
    logic [31:0] ins, pc;
    logic        intr;
    logic        ev;
    logic [31:0] ei, ep;
    logic        eint, efs;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic s, input logic f, input logic iv,
                      input logic [31:0] ins, input logic [31:0] pc, input logic intr,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                      input logic eint, input logic efs);
    vec_t v;
    v.s = s; v.f = f; v.iv = iv; v.ins = ins; v.pc = pc; v.intr = intr;
    v.ev = ev; v.ei = ei; v.ep = ep; v.eint = eint; v.efs = efs;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  // Held entries form a queue of at most two: head is what decode sees,
  // a second entry is the one waiting because decode was stalled.
  typedef struct {
    logic [31:0] ins, pc;
    logic        intr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  task automatic model_step(input logic s, input logic f, input logic iv,
                            input logic [31:0] ins, input logic [31:0] pc, input logic intr);
    ent_t e;
    int   n;
    e.ins = ins; e.pc = pc; e.intr = intr;
    n = mq.size();
    if (f) begin
      mq.delete();
    end else if (n == 2) begin
      if (!s) void'(mq.pop_front());
    end else begin
      if (n == 1 && !s) void'(mq.pop_front());
      if (iv) mq.push_back(e);
    end
    if (mq.size() > 0) m_pc = mq[0].pc;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    check_all("reset", 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    //     s  f  iv ins     pc      int | v  instr   pc      int fs
    addv(0, 0, 1, 32'h11, 32'h04, 0,   1, 32'h11, 32'h04, 0, 0);
    addv(0, 0, 1, 32'h22, 32'h08, 0,   1, 32'h22, 32'h08, 0, 0);
    addv(0, 0, 1, 32'h33, 32'h0c, 0,   1, 32'h33, 32'h0c, 0, 0);
    addv(0, 0, 1, 32'h44, 32'h10, 0,   1, 32'h44, 32'h10, 0, 0);
    // two-cycle fetch gap -> two bubbles
    addv(0, 0, 1, 32'h11, 32'h14, 0,   1, 32'h11, 32'h14, 0, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h14, 0, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h14, 0, 0);
    addv(0, 0, 1, 32'h22, 32'h18, 0,   1, 32'h22, 32'h18, 0, 0);
    // stall for three cycles with 0x22 arriving on the first one
    addv(0, 0, 1, 32'h11, 32'h1c, 0,   1, 32'h11, 32'h1c, 0, 0);
    addv(1, 0, 1, 32'h22, 32'h20, 0,   1, 32'h11, 32'h1c, 0, 1);
    addv(1, 0, 0, 32'h0,  32'h0,  0,   1, 32'h11, 32'h1c, 0, 1);
    addv(1, 0, 0, 32'h0,  32'h0,  0,   1, 32'h11, 32'h1c, 0, 1);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   1, 32'h22, 32'h20, 0, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h20, 0, 0);
    // flush with stall and a fetch while in SKID: 0x44 and 0x99 both dropped
    addv(0, 0, 1, 32'h33, 32'h24, 0,   1, 32'h33, 32'h24, 0, 0);
    addv(1, 0, 1, 32'h44, 32'h28, 0,   1, 32'h33, 32'h24, 0, 1);
    addv(1, 1, 1, 32'h99, 32'h2c, 0,   0, NOP,    32'h24, 0, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h24, 0, 0);
    // interrupt tag travels with its own entry through the skid
    addv(0, 0, 1, 32'h44, 32'h30, 0,   1, 32'h44, 32'h30, 0, 0);
    addv(1, 0, 1, 32'h55, 32'h34, 1,   1, 32'h44, 32'h30, 0, 1);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   1, 32'h55, 32'h34, 1, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h34, 0, 0);
    // EMPTY accepts even under stall; FULL+stall holds; flush from FULL
    addv(1, 0, 1, 32'h66, 32'h38, 1,   1, 32'h66, 32'h38, 1, 0);
    addv(1, 0, 0, 32'h0,  32'h0,  0,   1, 32'h66, 32'h38, 1, 0);
    addv(0, 1, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h38, 0, 0);
    // bubble after a tagged entry clears the tag
    addv(0, 0, 1, 32'h77, 32'h3c, 1,   1, 32'h77, 32'h3c, 1, 0);
    addv(0, 0, 0, 32'h0,  32'h0,  0,   0, NOP,    32'h3c, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].intr);
      tick();
      check_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].eint, tbl[i].efs);
    end

    // ---------------- asynchronous reset while in SKID ----------------
    drive(1'b0, 1'b0, 1'b1, 32'h11, 32'h100, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h22, 32'h104, 1'b1);
    tick();
    check_all("pre_arst", 1'b1, 32'h11, 32'h100, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_all("arst_immediate", 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    tick();
    check_all("arst_held", 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h77, 32'h40, 1'b0);
    tick();
    check_all("post_arst_fetch", 1'b1, 32'h77, 32'h40, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check_all("post_arst_bubble", 1'b0, NOP, 32'h40, 1'b0, 1'b0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    mq.delete();
    m_pc = 32'h0;
    for (int c = 0; c < 600; c++) begin
      logic        s, f, iv, intr;
      logic [31:0] ins, pc;
      s    = ($urandom_range(0, 99) < 30);
      f    = ($urandom_range(0, 99) < 8);
      iv   = ($urandom_range(0, 99) < 70);
      // fetch honours fetch_stall except when the same cycle flushes
      if (mq.size() == 2 && !f) iv = 1'b0;
      ins  = $urandom;
      pc   = $urandom;
      intr = $urandom_range(0, 1);
      drive(s, f, iv, ins, pc, intr);
      model_step(s, f, iv, ins, pc, intr);
      tick();
      check_all($sformatf("rand%0d", c),
                mq.size() > 0,
                (mq.size() > 0) ? mq[0].ins : NOP,
                m_pc,
                (mq.size() > 0) ? mq[0].intr : 1'b0,
                mq.size() == 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
